// File: rtl/alu_iter_pkg.sv
// Shared opcode, branch-code and state encodings for the iterative ALU.
package alu_iter_pkg;

  typedef logic [3:0] alu_op_t;
  typedef logic [2:0] br_op_t;

  localparam alu_op_t ALU_ADD   = 4'd0;
  localparam alu_op_t ALU_SUB   = 4'd1;
  localparam alu_op_t ALU_AND   = 4'd2;
  localparam alu_op_t ALU_OR    = 4'd3;
  localparam alu_op_t ALU_XOR   = 4'd4;
  localparam alu_op_t ALU_SLL   = 4'd5;
  localparam alu_op_t ALU_SRL   = 4'd6;
  localparam alu_op_t ALU_SRA   = 4'd7;
  localparam alu_op_t ALU_SLT   = 4'd8;
  localparam alu_op_t ALU_SLTU  = 4'd9;
  localparam alu_op_t ALU_MUL   = 4'd10;
  localparam alu_op_t ALU_MULHU = 4'd11;

  localparam br_op_t BR_BEQ  = 3'b000;
  localparam br_op_t BR_BNE  = 3'b001;
  localparam br_op_t BR_BLT  = 3'b100;
  localparam br_op_t BR_BGE  = 3'b101;
  localparam br_op_t BR_BLTU = 3'b110;
  localparam br_op_t BR_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mul_op(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Issue/result handshake bundle between the issue stage, the ALU and writeback.
interface alu_iter_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] alu_in_1;
  logic [WIDTH-1:0] alu_in_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             alu_bcond;
  logic             busy;

  modport slave (
    input  in_valid, alu_op, br_op, alu_in_1, alu_in_2, out_ready,
    output in_ready, out_valid, alu_result, alu_bcond, busy
  );

  modport master (
    output in_valid, alu_op, br_op, alu_in_1, alu_in_2, out_ready,
    input  in_ready, out_valid, alu_result, alu_bcond, busy
  );
endinterface

// File: rtl/alu_iter_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH steps.
// o_done/o_prod flag the final step so the caller can capture the product on that edge.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_kill,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_active;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = r_active & (r_cnt == LAST_STEP);
  assign o_done     = w_last;
  assign o_prod     = w_acc_next;

  // Operand shift registers, accumulator and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {SHAMT_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_kill) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {SHAMT_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= {SHAMT_W{1'b0}};
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      r_active <= ~w_last;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked integer ALU with branch-condition unit and an iterative multiplier.
// Results and branch outcome are registered; out_ready -> in_ready is the only comb path.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  alu_iter_if.slave   bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_result;
  logic               r_bcond;
  logic               r_hi;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_bcond;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_eq;
  logic               w_lt;
  logic               w_ltu;

  assign bus.in_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.busy       = (r_state == ST_MUL);
  assign bus.alu_result = r_result;
  assign bus.alu_bcond  = r_bcond;

  assign w_accept    = bus.in_valid & bus.in_ready;
  assign w_is_mul    = is_mul_op(bus.alu_op);
  assign w_mul_start = w_accept & w_is_mul & ~kill;
  assign w_shamt     = bus.alu_in_2[SHAMT_W-1:0];
  assign w_eq        = (bus.alu_in_1 == bus.alu_in_2);
  assign w_lt        = ($signed(bus.alu_in_1) < $signed(bus.alu_in_2));
  assign w_ltu       = (bus.alu_in_1 < bus.alu_in_2);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .i_kill  (kill),
    .i_start (w_mul_start),
    .i_a     (bus.alu_in_1),
    .i_b     (bus.alu_in_2),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  // Single-cycle datapath; multiply codes land in default and are served by mul_iter.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    case (bus.alu_op)
      ALU_ADD:  w_alu_res = bus.alu_in_1 + bus.alu_in_2;
      ALU_SUB:  w_alu_res = bus.alu_in_1 - bus.alu_in_2;
      ALU_AND:  w_alu_res = bus.alu_in_1 & bus.alu_in_2;
      ALU_OR:   w_alu_res = bus.alu_in_1 | bus.alu_in_2;
      ALU_XOR:  w_alu_res = bus.alu_in_1 ^ bus.alu_in_2;
      ALU_SLL:  w_alu_res = bus.alu_in_1 << w_shamt;
      ALU_SRL:  w_alu_res = bus.alu_in_1 >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(bus.alu_in_1) >>> w_shamt;
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_ltu};
      default:  w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // Branch-condition unit.
  always_comb begin
    w_bcond = 1'b0;
    case (bus.br_op)
      BR_BEQ:  w_bcond = w_eq;
      BR_BNE:  w_bcond = ~w_eq;
      BR_BLT:  w_bcond = w_lt;
      BR_BGE:  w_bcond = ~w_lt;
      BR_BLTU: w_bcond = w_ltu;
      BR_BGEU: w_bcond = ~w_ltu;
      default: w_bcond = 1'b0;
    endcase
  end

  // Next-state logic; kill is applied in the state register.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? ST_MUL : ST_DONE;
        else          w_state_next = ST_IDLE;
      end
      ST_MUL: begin
        if (w_mul_done) w_state_next = ST_DONE;
        else            w_state_next = ST_MUL;
      end
      ST_DONE: begin
        if (w_accept)           w_state_next = w_is_mul ? ST_MUL : ST_DONE;
        else if (bus.out_ready) w_state_next = ST_IDLE;
        else                    w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and result registers; outputs only change on accept or multiply completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= {WIDTH{1'b0}};
      r_bcond  <= 1'b0;
      r_hi     <= 1'b0;
    end else if (kill) begin
      r_state  <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_bcond <= w_bcond;
        r_hi    <= (bus.alu_op == ALU_MULHU);
        if (!w_is_mul) r_result <= w_alu_res;
      end else if ((r_state == ST_MUL) && w_mul_done) begin
        r_result <= r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: vector table, scoreboard and multi-cycle corner cases.
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;
  logic kill;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .kill  (kill),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         bc;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [2:0]   br;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         bc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard: one pop per result actually taken by the consumer.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: result 0x%0h with empty scoreboard (cycle %0d)",
                 bus.alu_result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {31'd0, bus.alu_result, bus.alu_bcond}, {31'd0, e.res, e.bc});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] br, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic push, input logic [W-1:0] er,
                       input logic eb, input logic chk_lat, output int acc_cyc);
    int waited;
    logic ok;
    exp_t e;
    waited = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.br_op    = br;
    bus.alu_in_1 = a;
    bus.alu_in_2 = b;
    e.res = er;
    e.bc  = eb;
    if (push) sb_q.push_back(e);
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: op %0d not accepted within 50 cycles", op);
    end else if (chk_lat) begin
      check("latency_1", {63'd0, bus.out_valid}, 64'd1);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL valid_timeout: out_valid not seen within 100 cycles");
    end
  endtask

  initial begin
    int c;
    int cs[4];
    int n;
    int busy_cnt;
    int bad;

    vecs[0]  = '{ALU_ADD,  BR_BEQ,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[1]  = '{ALU_SUB,  BR_BNE,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1};
    vecs[2]  = '{ALU_SRA,  BR_BLTU, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0};
    vecs[3]  = '{ALU_SRL,  BR_BGE,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0};
    vecs[4]  = '{ALU_SLL,  BR_BLT,  32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 1'b1};
    vecs[5]  = '{ALU_SLT,  BR_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
    vecs[6]  = '{ALU_SLTU, BR_BGEU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[7]  = '{ALU_ADD,  BR_BEQ,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{ALU_AND,  3'b010,  32'hF0F0_A5A5, 32'h0FF0_FF00, 32'h00F0_A500, 1'b0};
    vecs[9]  = '{ALU_OR,   BR_BGEU, 32'hF0F0_A5A5, 32'h0FF0_FF00, 32'hFFF0_FFA5, 1'b1};
    vecs[10] = '{ALU_XOR,  3'b011,  32'hF0F0_A5A5, 32'h0FF0_FF00, 32'hFF00_5AA5, 1'b0};
    vecs[11] = '{4'd12,    BR_BEQ,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1};
    vecs[12] = '{4'd15,    BR_BNE,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0};
    vecs[13] = '{ALU_SLL,  BR_BLTU, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b1};
    vecs[14] = '{ALU_SRA,  BR_BGE,  32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 1'b1};
    vecs[15] = '{ALU_SLT,  BR_BGE,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};

    reset = 1'b1;
    kill = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op = 4'd0;
    bus.br_op = 3'd0;
    bus.alu_in_1 = 32'd0;
    bus.alu_in_2 = 32'd0;
    #2;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_result", {32'd0, bus.alu_result}, 64'd0);
    check("rst_bcond", {63'd0, bus.alu_bcond}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    #20;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      issue(vecs[i].op, vecs[i].br, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].bc, 1'b1, c);
    @(posedge clk);
    #1;

    // Multiplies: busy for WIDTH cycles, result visible WIDTH+1 cycles after accept.
    issue(ALU_MUL, BR_BEQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0, c);
    n = 0;
    busy_cnt = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul_valid_cycle", 64'(n + 1), 64'd33);
    issue(ALU_MULHU, BR_BNE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, c);
    wait_valid();
    @(posedge clk);
    #1;

    // Backpressure: held result, no new accept, then four back-to-back ADDs.
    bus.out_ready = 1'b0;
    issue(ALU_ADD, BR_BEQ, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b1, c);
    bus.in_valid = 1'b1;
    bus.alu_in_1 = 32'd100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_result", {32'd0, bus.alu_result}, 64'd7);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(ALU_ADD, BR_BNE, 32'(i * 16), 32'd1, 1'b1, 32'(i * 16 + 1), 1'b1, 1'b1, cs[i]);
    for (int i = 1; i < 4; i++)
      check("b2b_accept_cycle", 64'(cs[i]), 64'(cs[0] + i));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // kill in the tenth multiply cycle.
    issue(ALU_MUL, BR_BEQ, 32'd3, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, c);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("kill_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("kill_busy", {63'd0, bus.busy}, 64'd0);
    bad = 0;
    repeat (40) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check("kill_no_result", 64'(bad), 64'd0);
    issue(ALU_MUL, BR_BLT, 32'd6, 32'd7, 1'b1, 32'd42, 1'b1, 1'b0, c);
    wait_valid();
    @(posedge clk);
    #1;

    // An accept coinciding with kill is dropped.
    bus.in_valid = 1'b1;
    bus.alu_op = ALU_ADD;
    bus.alu_in_1 = 32'd1;
    bus.alu_in_2 = 32'd1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_accept_valid", {63'd0, bus.out_valid}, 64'd0);
    check("kill_accept_busy", {63'd0, bus.busy}, 64'd0);

    // Asynchronous reset between edges while multiplying.
    issue(ALU_MUL, BR_BEQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0, c);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("areset_busy", {63'd0, bus.busy}, 64'd0);
    check("areset_result", {32'd0, bus.alu_result}, 64'd0);
    check("areset_bcond", {63'd0, bus.alu_bcond}, 64'd0);
    check("areset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", {62'd0, bus.busy, bus.out_valid}, 64'd0);
    issue(ALU_ADD, BR_BEQ, 32'd2, 32'd2, 1'b1, 32'd4, 1'b1, 1'b1, c);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes RV32-style integer ops at WIDTH bits with full variable shifts, set-less-than and a real branch-condition unit. It adds an iterative shift-add multiplier, so results return over a valid/ready interface with variable latency. It sits between the decode/issue stage and writeback, and a stalling pipeline uses it in place of the combinational ALU.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- SHAMT_W, $clog2(WIDTH): derived shift-amount width; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the block to IDLE immediately.
- kill  in  1  synchronous abort; drops any in-flight or held op.
- in_valid  in  1  issue request.
- in_ready  out  1  block accepts an op this cycle.
- alu_op  in  4  operation code (package constants).
- br_op  in  3  branch compare code (RISC-V funct3 encoding).
- alu_in_1  in  WIDTH  operand A.
- alu_in_2  in  WIDTH  operand B; low SHAMT_W bits are the shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- alu_result  out  WIDTH  registered result.
- alu_bcond  out  1  registered branch outcome.
- busy  out  1  high while a multiply is iterating.

## Operation
Ops:
- ADD 0, SUB 1, AND 2, OR 3, XOR 4: modulo 2^WIDTH.
- SLL 5, SRL 6, SRA 7: shift by alu_in_2[SHAMT_W-1:0]; SRA is sign-filling.
- SLT 8 (signed), SLTU 9 (unsigned): result is 0 or 1, zero-extended.
- MUL 10: low WIDTH bits of the unsigned 2·WIDTH-bit product.
- MULHU 11: high WIDTH bits of that product.
- Codes 12–15: result 0, latency 1.

Branch unit (alu_bcond):
- br_op 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- 010/011 give 0.
- Evaluated on the operands at accept and registered alongside the result, for every alu_op.

State machine, states IDLE, MUL, DONE:
- IDLE, accept of a non-multiply op: compute, register, go to DONE.
- IDLE, accept of MUL/MULHU: latch the operands, clear the 2·WIDTH accumulator, go to MUL.
- MUL: one shift-add step per cycle, with a counter counting 0..WIDTH-1. After exactly WIDTH cycles, select low/high and go to DONE.
- DONE, out_ready=1 with no new accept: go to IDLE.
- DONE, out_ready=1 with a simultaneous accept: go directly to the new op's next state.
- DONE, out_ready=0: hold; alu_result and alu_bcond stay stable.

Handshake signals:
- in_ready = (state==IDLE) | (state==DONE & out_ready). An op is accepted when in_valid & in_ready.
- out_valid = (state==DONE).
- busy = (state==MUL).

kill:
- Next state is IDLE from any state; out_valid is low the following cycle.
- An accept in the same cycle as kill is discarded.
- kill has priority over out_ready and in_valid.

Reset:
- state IDLE, counter 0, accumulator 0.
- alu_result 0, alu_bcond 0, out_valid 0, busy 0.
- in_ready is 1 while in reset; it is combinational from state.

## Timing
- Non-multiply op accepted at edge k: out_valid high from edge k+1.
- Multiply accepted at edge k: busy during cycles k+1..k+WIDTH; out_valid from edge k+WIDTH+1.
- Throughput: one non-multiply op per cycle when out_ready is held high.
- Multiply throughput: one per WIDTH+1 cycles.
- Operands are sampled only at accept; later changes to the inputs have no effect.
- Reset asserted mid-MUL clears all outputs asynchronously, without waiting for a clock edge.
- No combinational path from in_valid/operands to alu_result or out_valid. The only combinational input-to-output path is out_ready → in_ready.

## Structure
- Shared package (alu_func.vh-style include) holds:
  - the alu_op codes,
  - the br_op codes,
  - the IDLE/MUL/DONE state encoding.
- One natural sub-module, mul_iter: accumulator, operand shift registers, counter and done pulse, with a start/done interface.
- The combinational op/branch logic stays in alu_iter.

## Test plan
Bench runs at WIDTH=32 unless stated.
- ADD 0x7FFFFFFF+1 → 0x80000000; SUB 5−7 → 0xFFFFFFFE. Each has out_valid exactly 1 cycle after accept.
- Shifts of alu_in_1=0x80000000 with alu_in_2=0x24 (shamt 4):
  - SRA → 0xF8000000
  - SRL → 0x08000000
  - SLL → 0x00000000
- SLT(0xFFFFFFFF,1) → 1; SLTU → 0. With the same operands, br_op BLT → bcond 1, BGEU → 1, BEQ → 0.
- Multiply of 0xFFFFFFFF×0xFFFFFFFF:
  - MUL → 0x00000001 and MULHU → 0xFFFFFFFE.
  - busy for exactly 32 cycles; out_valid at cycle 33 after accept.
- Backpressure:
  - out_ready low for 3 cycles in DONE: result held, in_ready 0.
  - Then 4 back-to-back ADDs with out_ready high: 4 results on 4 consecutive cycles.
- kill and reset:
  - kill at MUL cycle 10: no out_valid, in_ready 1 next cycle.
  - Async reset pulse mid-MUL, between edges: out_valid/busy/alu_result are 0 before the next edge.
